// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a one-entry registered output slot
package id_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_GES, ALU_GEU
  } alu_opcode_e;
endpackage

module id_stage import id_stage_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      if_valid_i,
  output logic                      if_ready_o,
  input  logic [DATA_WIDTH-1:0]     if_instr_i,
  input  logic [DATA_WIDTH-1:0]     if_pc_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output alu_opcode_e               alu_operator_o,
  output logic [1:0]                op_a_sel_o,
  output logic                      op_b_sel_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic                      branch_o,
  output logic                      jump_o,
  output logic                      load_o,
  output logic                      store_o,
  output logic                      illegal_o,
  output logic [DATA_WIDTH-1:0]     pc_o
);
  typedef struct packed {
    alu_opcode_e               alu;
    logic [1:0]                a_sel;
    logic                      b_sel;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic                      we, br, jmp, ld, st, ill;
    logic [DATA_WIDTH-1:0]     pc;
  } dec_t;
  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e state;
  dec_t d, q;
  logic accept;
  logic [DATA_WIDTH-1:0] in;
  logic [6:0] opc, f7;
  logic [2:0] f3;

  // alt selects SUB/SRA; callers only raise it where the encoding allows
  function automatic alu_opcode_e arith(input logic [2:0] f, input logic alt);
    case (f)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign in  = if_instr_i;
  assign opc = in[6:0];
  assign f3  = in[14:12];
  assign f7  = in[31:25];

  always_comb begin
    d = '0;
    d.rs1 = in[19:15];
    d.rs2 = in[24:20];
    d.rd  = in[11:7];
    d.pc  = if_pc_i;
    case (opc)
      7'b0010011: begin
        d.b_sel = 1'b1;
        d.we = 1'b1;
        d.alu = arith(f3, in[30] && f3 == 3'b101);
        d.imm = (f3 == 3'b001 || f3 == 3'b101) ? {{(DATA_WIDTH-5){1'b0}}, in[24:20]}
                                               : {{(DATA_WIDTH-12){in[31]}}, in[31:20]};
        d.ill = (f3 == 3'b001 && f7 != 7'd0) ||
                (f3 == 3'b101 && f7 != 7'd0 && f7 != 7'b0100000);
      end
      7'b0110011: begin
        d.we = 1'b1;
        d.alu = arith(f3, in[30]);
        d.ill = !(f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      7'b0110111, 7'b0010111: begin
        d.a_sel = opc[5] ? 2'd2 : 2'd1;
        d.b_sel = 1'b1;
        d.we = 1'b1;
        d.imm = {in[31:12], 12'b0};
      end
      7'b1101111: begin
        d.a_sel = 2'd1;
        d.b_sel = 1'b1;
        d.we = 1'b1;
        d.jmp = 1'b1;
        d.imm = {{(DATA_WIDTH-20){in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
      end
      7'b1100111: begin
        d.b_sel = 1'b1;
        d.we = 1'b1;
        d.jmp = 1'b1;
        d.imm = {{(DATA_WIDTH-12){in[31]}}, in[31:20]};
        d.ill = f3 != 3'b000;
      end
      7'b1100011: begin
        d.br = 1'b1;
        d.imm = {{(DATA_WIDTH-12){in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
        d.alu = f3 == 3'b000 ? ALU_EQ : f3 == 3'b001 ? ALU_NE : f3 == 3'b100 ? ALU_SLT :
                f3 == 3'b101 ? ALU_GES : f3 == 3'b110 ? ALU_SLTU : ALU_GEU;
        d.ill = f3[2:1] == 2'b01;
      end
      7'b0000011: begin
        d.b_sel = 1'b1;
        d.we = 1'b1;
        d.ld = 1'b1;
        d.imm = {{(DATA_WIDTH-12){in[31]}}, in[31:20]};
      end
      7'b0100011: begin
        d.b_sel = 1'b1;
        d.st = 1'b1;
        d.imm = {{(DATA_WIDTH-12){in[31]}}, in[31:25], in[11:7]};
      end
      default: d.ill = 1'b1;
    endcase
    if (d.ill) begin
      d.alu = ALU_ADD;
      {d.we, d.br, d.jmp, d.ld, d.st} = '0;
    end
    if (d.rd == '0) d.we = 1'b0;
  end

  assign ex_valid_o = state == FULL;
  assign if_ready_o = !ex_valid_o || ex_ready_i;
  assign accept     = if_valid_i && if_ready_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= EMPTY;
      q <= '0;
    end else if (flush_i) state <= EMPTY;
    else if (accept) begin
      state <= FULL;
      q <= d;
    end else if (ex_ready_i) state <= EMPTY;
  end

  assign alu_operator_o = q.alu;
  assign op_a_sel_o     = q.a_sel;
  assign op_b_sel_o     = q.b_sel;
  assign imm_o          = q.imm;
  assign rs1_addr_o     = q.rs1;
  assign rs2_addr_o     = q.rs2;
  assign rd_addr_o      = q.rd;
  assign rd_we_o        = q.we;
  assign branch_o       = q.br;
  assign jump_o         = q.jmp;
  assign load_o         = q.ld;
  assign store_o        = q.st;
  assign illegal_o      = q.ill;
  assign pc_o           = q.pc;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage decode, handshake, stall, flush and reset
module tb_id_stage;
  import id_stage_pkg::*;

  logic clk = 0, rst_n = 0, flush = 0, if_valid = 0, ex_ready = 0;
  logic if_ready, ex_valid, b_sel, rd_we, branch, jump, load, store, illegal;
  logic [31:0] instr = 0, pc = 0, imm, pc_q;
  logic [1:0] a_sel;
  logic [4:0] rs1, rs2, rd;
  alu_opcode_e alu;
  int n_cmp = 0, n_err = 0;

  id_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .if_valid_i(if_valid), .if_ready_o(if_ready), .if_instr_i(instr), .if_pc_i(pc),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .alu_operator_o(alu), .op_a_sel_o(a_sel), .op_b_sel_o(b_sel), .imm_o(imm),
    .rs1_addr_o(rs1), .rs2_addr_o(rs2), .rd_addr_o(rd), .rd_we_o(rd_we),
    .branch_o(branch), .jump_o(jump), .load_o(load), .store_o(store),
    .illegal_o(illegal), .pc_o(pc_q)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
    n_cmp++; if (alu !== ALU_ADD) begin n_err++; $display("FAIL reset_alu got %0d exp %0d", alu, ALU_ADD); end
    n_cmp++; if (imm !== 32'd0 || pc_q !== 32'd0) begin n_err++; $display("FAIL reset_payload got imm %h pc %h exp 0", imm, pc_q); end
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", if_ready); end
  endtask

  task automatic test_addi;
    if_valid = 1; instr = 32'h00500093; pc = 32'h100; ex_ready = 0;
    @(negedge clk);
    if_valid = 0;
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b exp 1", ex_valid); end
    n_cmp++; if ({alu, a_sel, b_sel} !== {ALU_ADD, 2'd0, 1'b1}) begin n_err++; $display("FAIL addi_ops got %0d/%0d/%0d exp 0/0/1", alu, a_sel, b_sel); end
    n_cmp++; if ({imm, rd, rs1, rd_we, pc_q} !== {32'd5, 5'd1, 5'd0, 1'b1, 32'h100}) begin n_err++; $display("FAIL addi_fields got imm %h rd %0d rs1 %0d we %b pc %h exp 5/1/0/1/100", imm, rd, rs1, rd_we, pc_q); end
    ex_ready = 1;
    @(negedge clk);
    ex_ready = 0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain got %b exp 0", ex_valid); end
  endtask

  task automatic test_back_to_back;
    ex_ready = 1; if_valid = 1; instr = 32'h402081B3;
    @(negedge clk);
    instr = 32'h40335293;
    n_cmp++; if ({ex_valid, if_ready} !== 2'b11) begin n_err++; $display("FAIL b2b_hs1 got %b exp 11", {ex_valid, if_ready}); end
    n_cmp++; if ({alu, b_sel, rd, rs1, rs2, rd_we} !== {ALU_SUB, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1}) begin n_err++; $display("FAIL b2b_sub got alu %0d b %b rd %0d rs1 %0d rs2 %0d", alu, b_sel, rd, rs1, rs2); end
    @(negedge clk);
    if_valid = 0;
    n_cmp++; if ({ex_valid, if_ready} !== 2'b11) begin n_err++; $display("FAIL b2b_hs2 got %b exp 11", {ex_valid, if_ready}); end
    n_cmp++; if ({alu, b_sel, imm, rd, rs1} !== {ALU_SRA, 1'b1, 32'd3, 5'd5, 5'd6}) begin n_err++; $display("FAIL b2b_srai got alu %0d b %b imm %h rd %0d rs1 %0d", alu, b_sel, imm, rd, rs1); end
    @(negedge clk);
    ex_ready = 0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", ex_valid); end
  endtask

  task automatic test_stall;
    if_valid = 1; instr = 32'h00209463; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr = 32'h00500093;
      n_cmp++; if ({ex_valid, if_ready} !== 2'b10) begin n_err++; $display("FAIL stall_hs%0d got %b exp 10", i, {ex_valid, if_ready}); end
      n_cmp++; if ({alu, imm, branch, rd_we, b_sel} !== {ALU_NE, 32'd8, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL stall_bne%0d got alu %0d imm %h br %b we %b", i, alu, imm, branch, rd_we); end
    end
    ex_ready = 1; if_valid = 0;
    @(negedge clk);
    ex_ready = 0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got %b exp 0", ex_valid); end
  endtask

  task automatic test_lui_illegal;
    ex_ready = 1; if_valid = 1; instr = 32'h123453B7;
    @(negedge clk);
    instr = 32'h00000000;
    n_cmp++; if ({ex_valid, alu, a_sel, imm, rd, rd_we} !== {1'b1, ALU_ADD, 2'd2, 32'h12345000, 5'd7, 1'b1}) begin n_err++; $display("FAIL lui got v %b alu %0d a %0d imm %h rd %0d", ex_valid, alu, a_sel, imm, rd); end
    @(negedge clk);
    if_valid = 0;
    n_cmp++; if ({ex_valid, illegal, alu} !== {1'b1, 1'b1, ALU_ADD}) begin n_err++; $display("FAIL illegal got v %b ill %b alu %0d exp 1/1/0", ex_valid, illegal, alu); end
    n_cmp++; if ({rd_we, branch, jump, load, store} !== 5'b0) begin n_err++; $display("FAIL illegal_flags got %b exp 00000", {rd_we, branch, jump, load, store}); end
    @(negedge clk);
    ex_ready = 0;
  endtask

  task automatic test_jal;
    ex_ready = 1; if_valid = 1; instr = 32'hFFDFF0EF;
    @(negedge clk);
    if_valid = 0;
    n_cmp++; if ({ex_valid, a_sel, imm, jump, rd_we, illegal} !== {1'b1, 2'd1, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0}) begin n_err++; $display("FAIL jal got a %0d imm %h j %b we %b ill %b", a_sel, imm, jump, rd_we, illegal); end
    @(negedge clk);
    ex_ready = 0;
  endtask

  task automatic test_flush;
    if_valid = 1; instr = 32'h00500093; ex_ready = 0;
    @(negedge clk);
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL flush_fill got %b exp 1", ex_valid); end
    flush = 1; instr = 32'h123453B7; ex_ready = 1;
    @(negedge clk);
    flush = 0; if_valid = 0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", ex_valid); end
    @(negedge clk);
    ex_ready = 0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got %b exp 0", ex_valid); end
  endtask

  task automatic test_reset_mid;
    if_valid = 1; instr = 32'h402081B3; ex_ready = 0;
    @(negedge clk);
    if_valid = 0;
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_fill got %b exp 1", ex_valid); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({ex_valid, alu} !== {1'b0, ALU_ADD}) begin n_err++; $display("FAIL rstmid_async got v %b alu %0d exp 0/0", ex_valid, alu); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if ({ex_valid, if_ready} !== 2'b01) begin n_err++; $display("FAIL rstmid_release got %b exp 01", {ex_valid, if_ready}); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_stall;
    test_lui_illegal;
    test_jal;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode pipeline stage for the RV32I core. It sits between fetch and execute.
- Accepts 32-bit instructions from fetch over a valid/ready handshake.
- Decodes each instruction into an ALU operator (alu_opcode_e), operand-source selects, an immediate, register addresses and control flags.
- Registers the result in a single output slot. Execute drains that slot over a second valid/ready handshake. It supports stall and flush.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and immediate.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  discard the held slot and any instruction being accepted this cycle.
- if_valid_i  input  1  fetch presents an instruction.
- if_ready_o  output  1  stage can accept this cycle.
- if_instr_i  input  DATA_WIDTH  instruction word.
- if_pc_i  input  DATA_WIDTH  PC of the instruction.
- ex_valid_o  output  1  decoded slot valid.
- ex_ready_i  input  1  execute consumes the slot this cycle.
- alu_operator_o  output  alu_opcode_e  ALU operation.
- op_a_sel_o  output  2  0 = rs1, 1 = PC, 2 = zero.
- op_b_sel_o  output  1  0 = rs2, 1 = immediate.
- imm_o  output  DATA_WIDTH  sign- or zero-extended immediate.
- rs1_addr_o, rs2_addr_o, rd_addr_o  output  REG_ADDR_WIDTH each  register addresses.
- rd_we_o  output  1  instruction writes rd (forced 0 when rd = x0).
- branch_o, jump_o, load_o, store_o  output  1 each  instruction class flags.
- illegal_o  output  1  unsupported encoding.
- pc_o  output  DATA_WIDTH  PC of the decoded instruction.

Behaviour:
- **Reset (rst_ni low, async):**
  - ex_valid_o = 0.
  - All payload outputs = 0, which gives alu_operator_o = ALU_ADD.
  - if_ready_o = 1 once reset is released.
- **Slot state:** one-entry slot, states EMPTY and FULL.
  - if_ready_o = !ex_valid_o || ex_ready_i. This is a combinational pass-through of ready, with no bubble on back-to-back flow.
- **Accept:** when if_valid_i && if_ready_o && !flush_i, the decoded payload is captured at the clock edge and ex_valid_o = 1 next cycle.
  - Latency is exactly 1 cycle from accept to ex_valid_o.
- **Drain:** when ex_valid_o && ex_ready_i with no simultaneous accept, ex_valid_o = 0 next cycle.
  - On a simultaneous drain and accept, the slot is overwritten and stays FULL.
- **Stall:** while ex_valid_o && !ex_ready_i, all outputs hold stable and if_ready_o = 0.
- **Flush:** flush_i has priority over everything.
  - Next cycle ex_valid_o = 0. Payload may keep stale values.
  - An instruction offered in the flush cycle is dropped, not captured.
- **Decode table** (funct3 / funct7 per RV32I):
  - OP-IMM and OP: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU map to the matching ALU_* code. SUB and SRA are selected by instr[30].
  - OP-IMM: op_b_sel = 1.
    - Shift-immediates use imm = zero-extended shamt instr[24:20].
    - A shift-immediate with nonzero instr[31:25] other than SRAI 0100000 is illegal.
  - OP: funct7 must be 0000000, or 0100000 for ADD/SRL positions only; anything else is illegal.
  - LUI: op_a_sel = 2, imm = {instr[31:12], 12'b0}, ALU_ADD.
  - AUIPC: op_a_sel = 1, same imm, ALU_ADD.
  - JAL: op_a_sel = 1, imm = J-imm, jump = 1, rd_we = 1.
  - JALR: funct3 must be 000; op_a_sel = 0, imm = I-imm, jump = 1.
  - BRANCH: op_b_sel = 0, imm = B-imm, branch = 1, rd_we = 0.
    - BEQ→ALU_EQ, BNE→ALU_NE, BLT→ALU_SLT, BGE→ALU_GES, BLTU→ALU_SLTU, BGEU→ALU_GEU.
    - funct3 010 and 011 are illegal.
  - LOAD: ALU_ADD, I-imm, load = 1.
  - STORE: ALU_ADD, S-imm, store = 1, rd_we = 0.
- **Illegal encodings:** any other opcode, or instr[1:0] != 11.
  - illegal_o = 1, rd_we/branch/jump/load/store all 0, alu_operator = ALU_ADD.
  - The slot is still valid so execute can raise the exception.
- **Immediates:** all immediates except shift amounts are sign-extended from the instruction MSB.

Test Plan:
- Reset mid-stream with a slot FULL → ex_valid_o = 0 immediately (async), if_ready_o = 1 after release.
- Accept 0x00500093 (ADDI x1,x0,5) → next cycle ex_valid_o = 1, ALU_ADD, op_a_sel = 0, op_b_sel = 1, imm = 5, rd = 1, rd_we = 1.
- Back-to-back 0x402081B3 (SUB x3,x1,x2) then 0x40335293 (SRAI x5,x6,3) with ex_ready_i = 1 → first cycle ALU_SUB, op_b_sel = 0; next cycle ALU_SRA, imm = 3; if_ready_o never drops.
- Accept 0x00209463 (BNE x1,x2,+8) with ex_ready_i held 0 for 3 cycles → ALU_NE, imm = 8, branch = 1, rd_we = 0; outputs stable and if_ready_o = 0 throughout; drains on the first ready cycle.
- Accept 0x123453B7 (LUI x7,0x12345) → op_a_sel = 2, imm = 0x12345000, ALU_ADD. Then accept 0x00000000 → illegal_o = 1, all flags 0.
- Slot FULL and if_valid_i = 1 with flush_i = 1 → next cycle ex_valid_o = 0 and the offered instruction is never emitted.
